// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice made of two half adders is reused
// for every operand bit under a start/busy/done FSM.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s1_s, c1_s, s2_s, c2_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             unused_res_lsb_s;

    half_adder u_ha1 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(s1_s), .c_o(c1_s));
    half_adder u_ha2 (.a_i(s1_s),      .b_i(cy_q),      .s_o(s2_s), .c_o(c2_s));

    assign carry_next_s = c1_s | c2_s;

    // New result bit enters at the MSB; the old LSB falls off the end and is never read.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next_s = s2_s;
        end else begin : g_res_wn
            assign res_next_s = {s2_s, res_sh_q[WIDTH-1:1]};
        end
    endgenerate
    assign unused_res_lsb_s = res_sh_q[0];

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_sh_q    <= {WIDTH{1'b0}};
            cy_q        <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath sequencing and registered-output decode.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            // The edge leaving DONE is the first IDLE sampling point, giving a WIDTH+1 period.
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cy_d    = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_sh_d = res_next_s;
                cy_d     = carry_next_s;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    sum_d       = res_next_s;
                    carry_out_d = carry_next_s;
                    state_d     = DONE;
                    done_d      = 1'b1;
                end else begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule
